// File: rtl/image_rom_arbiter.sv
// image_rom_arbiter: shares one single-port synchronous image ROM between the display fetch and an aux reader.
// Optional aux starvation guard is enabled by defining IMAGE_ROM_ARBITER_AUX_STARVE_GUARD_EN.
module image_rom_arbiter #(
  parameter int ROM_ADDR_BUS_WIDTH = 17,
  parameter int DATA_WIDTH         = 24,
  parameter int ROM_LATENCY        = 2,
  parameter int STARVE_LIMIT       = 800
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          disp_req,
  input  logic [ROM_ADDR_BUS_WIDTH-1:0] disp_addr,
  output logic [DATA_WIDTH-1:0]         disp_data,
  output logic                          disp_valid,
  output logic                          disp_miss,
  input  logic                          aux_req,
  input  logic [ROM_ADDR_BUS_WIDTH-1:0] aux_addr,
  output logic                          aux_ready,
  output logic [DATA_WIDTH-1:0]         aux_data,
  output logic                          aux_valid,
  output logic [ROM_ADDR_BUS_WIDTH-1:0] rom_addr,
  output logic                          rom_rden,
  input  logic [DATA_WIDTH-1:0]         rom_q
);

  localparam int DEPTH = ROM_LATENCY + 1;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_DISP = 2'd1,
    ARB_AUX  = 2'd2
  } arb_state_e;

  arb_state_e                    state_q, state_d;
  logic [ROM_ADDR_BUS_WIDTH-1:0] rom_addr_q, rom_addr_d;
  logic [DEPTH-1:0]              own_disp_q, own_disp_d;
  logic [DEPTH-1:0]              own_aux_q, own_aux_d;
  logic [DEPTH-1:0]              own_miss_q, own_miss_d;
  logic [DATA_WIDTH-1:0]         disp_data_q, disp_data_d;
  logic [DATA_WIDTH-1:0]         aux_data_q, aux_data_d;
  logic                          disp_valid_q, disp_valid_d;
  logic                          disp_miss_q, disp_miss_d;
  logic                          aux_valid_q, aux_valid_d;
  logic                          force_slot;
  logic                          disp_drop;

`ifdef IMAGE_ROM_ARBITER_AUX_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

  assign force_slot = (starve_cnt_q == CNT_W'(STARVE_LIMIT));

  // Count consecutive denied aux cycles; any acceptance or withdrawal restarts the count.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!aux_req || aux_ready) begin
      starve_cnt_d = '0;
    end else if (!force_slot) begin
      starve_cnt_d = starve_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end
`else
  assign force_slot = 1'b0;
`endif

  assign aux_ready = rst_n & (~disp_req | force_slot);
  assign disp_drop = disp_req & force_slot & aux_req;

  always_comb begin
    state_d    = ARB_IDLE;
    rom_addr_d = rom_addr_q;
    if (disp_req && !disp_drop) begin
      state_d    = ARB_DISP;
      rom_addr_d = disp_addr;
    end else if (aux_req) begin
      state_d    = ARB_AUX;
      rom_addr_d = aux_addr;
    end
  end

  // Owner tags ride alongside the ROM latency; the last stage lines up with rom_q.
  always_comb begin
    own_disp_d   = {own_disp_q[DEPTH-2:0], state_d == ARB_DISP};
    own_aux_d    = {own_aux_q[DEPTH-2:0], state_d == ARB_AUX};
    own_miss_d   = {own_miss_q[DEPTH-2:0], disp_drop};
    disp_valid_d = own_disp_q[DEPTH-1] | own_miss_q[DEPTH-1];
    disp_miss_d  = own_miss_q[DEPTH-1];
    disp_data_d  = own_disp_q[DEPTH-1] ? rom_q : disp_data_q;
    aux_valid_d  = own_aux_q[DEPTH-1];
    aux_data_d   = own_aux_q[DEPTH-1] ? rom_q : aux_data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ARB_IDLE;
      rom_addr_q   <= '0;
      own_disp_q   <= '0;
      own_aux_q    <= '0;
      own_miss_q   <= '0;
      disp_data_q  <= '0;
      disp_valid_q <= 1'b0;
      disp_miss_q  <= 1'b0;
      aux_data_q   <= '0;
      aux_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      rom_addr_q   <= rom_addr_d;
      own_disp_q   <= own_disp_d;
      own_aux_q    <= own_aux_d;
      own_miss_q   <= own_miss_d;
      disp_data_q  <= disp_data_d;
      disp_valid_q <= disp_valid_d;
      disp_miss_q  <= disp_miss_d;
      aux_data_q   <= aux_data_d;
      aux_valid_q  <= aux_valid_d;
    end
  end

  assign rom_addr   = rom_addr_q;
  assign rom_rden   = (state_q != ARB_IDLE);
  assign disp_data  = disp_data_q;
  assign disp_valid = disp_valid_q;
  assign disp_miss  = disp_miss_q;
  assign aux_data   = aux_data_q;
  assign aux_valid  = aux_valid_q;

endmodule

// File: tb/tb_image_rom_arbiter.sv
// Self-checking bench for image_rom_arbiter: directed vector table, reset and starvation sequences,
// and random traffic checked against a slot-scheduling reference model.
module tb_image_rom_arbiter;

  localparam int AW    = 17;
  localparam int DW    = 24;
  localparam int LAT   = 2;
  localparam int LIMIT = 4;
  localparam int NCYC  = 1024;

`ifdef IMAGE_ROM_ARBITER_AUX_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          disp_req;
  logic [AW-1:0] disp_addr;
  logic [DW-1:0] disp_data;
  logic          disp_valid;
  logic          disp_miss;
  logic          aux_req;
  logic [AW-1:0] aux_addr;
  logic          aux_ready;
  logic [DW-1:0] aux_data;
  logic          aux_valid;
  logic [AW-1:0] rom_addr;
  logic          rom_rden;
  logic [DW-1:0] rom_q;

  always #5 clk = ~clk;

  image_rom_arbiter #(
    .ROM_ADDR_BUS_WIDTH(AW),
    .DATA_WIDTH        (DW),
    .ROM_LATENCY       (LAT),
    .STARVE_LIMIT      (LIMIT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .disp_req  (disp_req),
    .disp_addr (disp_addr),
    .disp_data (disp_data),
    .disp_valid(disp_valid),
    .disp_miss (disp_miss),
    .aux_req   (aux_req),
    .aux_addr  (aux_addr),
    .aux_ready (aux_ready),
    .aux_data  (aux_data),
    .aux_valid (aux_valid),
    .rom_addr  (rom_addr),
    .rom_rden  (rom_rden),
    .rom_q     (rom_q)
  );

  // ROM contents are addr + 0x100000, delivered LAT edges after the address is registered
  function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
    return DW'(a) + 24'h100000;
  endfunction

  logic [AW-1:0] rom_pipe [LAT];
  always @(posedge clk) begin
    rom_pipe[0] <= rom_addr;
    for (int i = 1; i < LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
  end
  assign rom_q = rom_word(rom_pipe[LAT-1]);

  typedef struct {
    logic          dr;
    logic [AW-1:0] da;
    logic          ar;
    logic [AW-1:0] aa;
    logic          exp_rden;
    logic [AW-1:0] exp_addr;
  } vec_t;

  // Reference model: per-cycle expectation slots filled when a request is served
  bit            exp_dv [NCYC];
  bit            exp_dm [NCYC];
  bit            exp_av [NCYC];
  logic [DW-1:0] exp_dd [NCYC];
  logic [DW-1:0] exp_ad [NCYC];
  logic [DW-1:0] mdl_dd;
  logic [DW-1:0] mdl_ad;
  int            starve;
  int            cyc;
  int            n_checks;
  int            n_fail;
  int            miss_seen;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic checkOutput();
    if (exp_dv[cyc] && !exp_dm[cyc]) mdl_dd = exp_dd[cyc];
    if (exp_av[cyc]) mdl_ad = exp_ad[cyc];
    check("disp_valid", disp_valid, exp_dv[cyc]);
    check("disp_miss", disp_miss, exp_dm[cyc]);
    check("disp_data", disp_data, mdl_dd);
    check("aux_valid", aux_valid, exp_av[cyc]);
    check("aux_data", aux_data, mdl_ad);
    if (disp_miss) miss_seen++;
  endtask

  task automatic applyStimulus(input logic dr, input logic [AW-1:0] da,
                               input logic ar, input logic [AW-1:0] aa,
                               output bit accepted);
    bit forced;
    bit ready_exp;
    int idx;
    disp_req  = dr;
    disp_addr = da;
    aux_req   = ar;
    aux_addr  = aa;
    #1;
    forced    = GUARD && (starve == LIMIT);
    ready_exp = !dr || forced;
    check("aux_ready", aux_ready, ready_exp);
    accepted = ar && ready_exp;
    idx = cyc + LAT + 2;
    if (idx < NCYC) begin
      if (dr && !accepted) begin
        exp_dv[idx] = 1'b1;
        exp_dd[idx] = rom_word(da);
      end
      if (dr && accepted) begin
        exp_dv[idx] = 1'b1;
        exp_dm[idx] = 1'b1;
      end
      if (accepted) begin
        exp_av[idx] = 1'b1;
        exp_ad[idx] = rom_word(aa);
      end
    end
    starve = (!ar || accepted) ? 0 : starve + 1;
    @(posedge clk);
    #1;
    cyc++;
    checkOutput();
  endtask

  function automatic vec_t mk(input logic dr, input logic [AW-1:0] da, input logic ar,
                              input logic [AW-1:0] aa, input logic rd, input logic [AW-1:0] ea);
    vec_t v;
    v.dr = dr; v.da = da; v.ar = ar; v.aa = aa; v.exp_rden = rd; v.exp_addr = ea;
    return v;
  endfunction

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t vecs[$];
    bit   acc;
    bit   pend;
    logic [AW-1:0] paddr;
    int   first_ready;

    n_checks = 0; n_fail = 0; cyc = 0; starve = 0; miss_seen = 0;
    mdl_dd = '0; mdl_ad = '0;

    // display 0,1,2 back to back, then idle
    vecs.push_back(mk(1, 17'h00000, 0, 17'h00000, 1, 17'h00000));
    vecs.push_back(mk(1, 17'h00001, 0, 17'h00000, 1, 17'h00001));
    vecs.push_back(mk(1, 17'h00002, 0, 17'h00000, 1, 17'h00002));
    vecs.push_back(mk(0, 17'h00000, 0, 17'h00000, 0, 17'h00002));
    // aux blocked by display, then accepted when the display goes idle
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(1, AW'(17'h10 + i), 1, 17'h1D4C0, 1, AW'(17'h10 + i)));
    vecs.push_back(mk(0, 17'h00000, 1, 17'h1D4C0, 1, 17'h1D4C0));
    vecs.push_back(mk(0, 17'h00000, 0, 17'h00000, 0, 17'h1D4C0));
    // display and aux interleaved
    for (int i = 0; i < 4; i++) begin
      vecs.push_back(mk(1, AW'(17'h20 + i), 1, AW'(17'hA0 + i), 1, AW'(17'h20 + i)));
      vecs.push_back(mk(0, 17'h00000, 1, AW'(17'hA0 + i), 1, AW'(17'hA0 + i)));
    end
    vecs.push_back(mk(0, 17'h00000, 0, 17'h00000, 0, 17'h000A3));

    rst_n = 1'b0; disp_req = 1'b0; disp_addr = '0; aux_req = 1'b0; aux_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_rom_rden", rom_rden, 0);
    check("reset_aux_ready", aux_ready, 0);
    check("reset_disp_valid", disp_valid, 0);
    check("reset_aux_valid", aux_valid, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      applyStimulus(0, '0, 0, '0, acc);
      check("idle_rom_rden", rom_rden, 0);
      check("idle_rom_addr", rom_addr, 0);
    end

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].dr, vecs[i].da, vecs[i].ar, vecs[i].aa, acc);
      check("vec_rom_rden", rom_rden, vecs[i].exp_rden);
      check("vec_rom_addr", rom_addr, vecs[i].exp_addr);
    end
    for (int i = 0; i < 5; i++) applyStimulus(0, '0, 0, '0, acc);

    // reset while a display and an aux read are in flight
    applyStimulus(1, 17'h00030, 0, '0, acc);
    applyStimulus(0, '0, 1, 17'h00031, acc);
    disp_req = 1'b0; aux_req = 1'b0;
    rst_n = 1'b0;
    #1;
    check("async_rst_rom_rden", rom_rden, 0);
    check("async_rst_rom_addr", rom_addr, 0);
    check("async_rst_disp_data", disp_data, 0);
    check("async_rst_aux_data", aux_data, 0);
    check("async_rst_aux_ready", aux_ready, 0);
    for (int i = cyc + 1; i < NCYC; i++) begin
      exp_dv[i] = 1'b0; exp_dm[i] = 1'b0; exp_av[i] = 1'b0;
    end
    mdl_dd = '0; mdl_ad = '0; starve = 0;
    @(posedge clk);
    #1;
    cyc++;
    check("in_rst_disp_valid", disp_valid, 0);
    check("in_rst_aux_valid", aux_valid, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) applyStimulus(0, '0, 0, '0, acc);

    // continuous display with a waiting aux request
    first_ready = -1;
    miss_seen = 0;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1, AW'(17'h40 + i), first_ready < 0, 17'h1ABCD, acc);
      if (acc && first_ready < 0) first_ready = i + 1;
    end
    for (int i = 0; i < 5; i++) applyStimulus(0, '0, 0, '0, acc);
    check("starve_first_accept", first_ready, GUARD ? 32'd5 : 32'hFFFF_FFFF);
    check("starve_miss_count", miss_seen, GUARD ? 32'd1 : 32'd0);

    // random traffic; aux holds its request and address until accepted or withdrawn
    pend = 1'b0; paddr = '0;
    for (int i = 0; i < 300; i++) begin
      logic dr;
      dr = ($urandom_range(0, 99) < 60);
      if (!pend && $urandom_range(0, 99) < 50) begin
        pend  = 1'b1;
        paddr = AW'($urandom);
      end else if (pend && $urandom_range(0, 99) < 3) begin
        pend = 1'b0;
      end
      applyStimulus(dr, AW'($urandom), pend, paddr, acc);
      if (acc) pend = 1'b0;
    end
    for (int i = 0; i < 6; i++) applyStimulus(0, '0, 0, '0, acc);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
